// File: rtl/jtag_scan_master_pkg.sv
// Shared types for the JTAG scan master: command opcodes, TAP states,
// controller states and the TMS sequencing helpers.
package jtag_scan_master_pkg;

  localparam int MAX_LEN_DEF = 38;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00,
    OP_IR    = 2'b01,
    OP_DR    = 2'b10,
    OP_IDLE  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    TAP_RESET   = 3'd0,
    TAP_RTI     = 3'd1,
    TAP_SEL_DR  = 3'd2,
    TAP_SEL_IR  = 3'd3,
    TAP_CAPTURE = 3'd4,
    TAP_SHIFT   = 3'd5,
    TAP_EXIT1   = 3'd6,
    TAP_UPDATE  = 3'd7
  } tap_e;

  typedef enum logic [1:0] {
    CTL_IDLE = 2'b00,
    CTL_TRST = 2'b01,
    CTL_CMD  = 2'b10
  } ctl_e;

  function automatic logic is_scan(input op_e op);
    return (op == OP_IR) || (op == OP_DR);
  endfunction

  // TCK cycles spent walking from RTI into SHIFT
  function automatic logic [6:0] scan_pre(input op_e op);
    return (op == OP_IR) ? 7'd4 : 7'd3;
  endfunction

  function automatic logic tms_bit(input logic seg_rst, input op_e op,
                                   input logic [5:0] len, input logic [6:0] step);
    logic [6:0] pre;
    logic [6:0] body;
    logic       r;
    pre  = scan_pre(op);
    body = pre + {1'b0, len};
    if (seg_rst) begin
      r = (step < 7'd5);
    end else if (op == OP_IDLE) begin
      r = 1'b0;
    end else if (step < pre) begin
      r = (step == 7'd0) || ((op == OP_IR) && (step == 7'd1));
    end else if (step < body) begin
      r = (step == body - 7'd1);
    end else begin
      r = (step == body);
    end
    return r;
  endfunction

  // PAUSE is not modelled: the master never drives tms=0 from EXIT1
  function automatic tap_e tap_next(input tap_e s, input logic t);
    tap_e n;
    case (s)
      TAP_RESET:   n = t ? TAP_RESET  : TAP_RTI;
      TAP_RTI:     n = t ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:  n = t ? TAP_SEL_IR : TAP_CAPTURE;
      TAP_SEL_IR:  n = t ? TAP_RESET  : TAP_CAPTURE;
      TAP_CAPTURE: n = t ? TAP_EXIT1  : TAP_SHIFT;
      TAP_SHIFT:   n = t ? TAP_EXIT1  : TAP_SHIFT;
      TAP_EXIT1:   n = t ? TAP_UPDATE : TAP_SHIFT;
      TAP_UPDATE:  n = t ? TAP_SEL_DR : TAP_RTI;
      default:     n = TAP_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_scan_master_if.sv
// Command/response channel of the JTAG scan master; master drives commands,
// slave (the scan master) returns one response per command.
interface jtag_scan_master_if
  import jtag_scan_master_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  op_e                cmd_op;
  logic [5:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_err;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_err, rsp_data
  );

endinterface

// File: rtl/jtag_scan_master_tckgen.sv
// TCK divider: TCK_DIV clk cycles low then TCK_DIV high while enabled,
// parked low otherwise; strobes fire on the cycle whose edge moves tck.
module jtag_scan_master_tckgen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_tck,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] LP_LAST = 8'(TCK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_tck;
  logic       w_wrap;

  assign w_wrap = i_en && (r_cnt == LP_LAST);

  // Half-period counter and tck register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 8'd0;
      r_tck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= 8'd0;
      r_tck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= 8'd0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tck  = r_tck;
  assign o_rise = w_wrap && !r_tck;
  assign o_fall = w_wrap && r_tck;

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: runs TAP reset, IR/DR scans and idle clocking from a
// command channel. Define JTAG_SCAN_MASTER_TRST_EN to add a trst_n output.
module jtag_scan_master
  import jtag_scan_master_pkg::*;
#(
  parameter int TCK_DIV = 4,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  jtag_scan_master_if.slave   bus,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
`ifdef JTAG_SCAN_MASTER_TRST_EN
  output logic                trst_n,
`endif
  input  logic                tdo
);

  localparam int         IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [6:0] LP_MAX = 7'(MAX_LEN);

  ctl_e               r_state, w_state_nxt;
  op_e                r_op;
  logic [5:0]         r_len;
  logic [MAX_LEN-1:0] r_data, r_cap, r_rsp_data;
  logic [6:0]         r_step;
  logic               r_tms, r_tdi, r_cmd_ready, r_rsp_valid, r_rsp_err, r_tap_known;
  tap_e               r_tap;

  logic               w_rise, w_fall, w_tck, w_run;
  logic               w_accept, w_bad, w_imm_done, w_finish, w_last, w_seg_end;
  logic [6:0]         w_pre, w_body, w_seg_len, w_step_n;
  logic               w_in_shift_cur, w_in_shift_nxt, w_tdi_nxt, w_tms_nxt, w_tms_start;
  logic [IW-1:0]      w_idx_cur, w_idx_nxt;

  assign w_run = (r_state != CTL_IDLE);

  jtag_scan_master_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_run),
    .o_tck   (w_tck),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Step bookkeeping: segment length, shift window and next tms/tdi
  always_comb begin
    w_accept = bus.cmd_valid && r_cmd_ready;
    w_bad    = is_scan(bus.cmd_op) &&
               ((bus.cmd_len == 6'd0) || ({1'b0, bus.cmd_len} > LP_MAX));
    w_pre    = scan_pre(r_op);
    w_body   = w_pre + {1'b0, r_len};
    case (r_state)
      CTL_TRST: w_seg_len = 7'd6;
      CTL_CMD:  w_seg_len = (r_op == OP_IDLE) ? {1'b0, r_len} : (w_body + 7'd2);
      default:  w_seg_len = 7'd6;
    endcase
    w_last         = (r_step == w_seg_len - 7'd1);
    w_seg_end      = w_fall && w_last;
    w_step_n       = r_step + 7'd1;
    w_in_shift_cur = (r_state == CTL_CMD) && is_scan(r_op) && (r_step >= w_pre) && (r_step < w_body);
    w_in_shift_nxt = (r_state == CTL_CMD) && is_scan(r_op) && (w_step_n >= w_pre) && (w_step_n < w_body);
    w_idx_cur      = IW'(r_step - w_pre);
    w_idx_nxt      = IW'(w_step_n - w_pre);
    w_tdi_nxt      = w_in_shift_nxt ? r_data[w_idx_nxt] : 1'b0;
    w_tms_nxt      = tms_bit(r_state == CTL_TRST, r_op, r_len, w_step_n);
  end

  // Controller next-state and first-step tms of the segment being entered
  always_comb begin
    w_state_nxt = r_state;
    w_imm_done  = 1'b0;
    w_finish    = 1'b0;
    w_tms_start = 1'b0;
    case (r_state)
      CTL_IDLE: begin
        if (w_accept) begin
          if (w_bad) begin
            w_imm_done = 1'b1;
          end else if ((bus.cmd_op == OP_RESET) || !r_tap_known) begin
            w_state_nxt = CTL_TRST;
          end else if ((bus.cmd_op == OP_IDLE) && (bus.cmd_len == 6'd0)) begin
            w_imm_done = 1'b1;
          end else begin
            w_state_nxt = CTL_CMD;
          end
        end else begin
          w_state_nxt = CTL_IDLE;
        end
      end
      CTL_TRST: begin
        if (w_seg_end) begin
          if ((r_op == OP_RESET) || ((r_op == OP_IDLE) && (r_len == 6'd0))) begin
            w_state_nxt = CTL_IDLE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = CTL_CMD;
          end
        end else begin
          w_state_nxt = CTL_TRST;
        end
      end
      CTL_CMD: begin
        if (w_seg_end) begin
          w_state_nxt = CTL_IDLE;
          w_finish    = 1'b1;
        end else begin
          w_state_nxt = CTL_CMD;
        end
      end
      default: w_state_nxt = CTL_IDLE;
    endcase
    if (w_state_nxt == CTL_TRST) begin
      w_tms_start = 1'b1;
    end else if (r_state == CTL_IDLE) begin
      w_tms_start = tms_bit(1'b0, bus.cmd_op, bus.cmd_len, 7'd0);
    end else begin
      w_tms_start = tms_bit(1'b0, r_op, r_len, 7'd0);
    end
  end

  // Controller state register; ready mirrors the idle state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= CTL_IDLE;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == CTL_IDLE);
    end
  end

  // Command latch, pin drive, TAP tracking, capture and response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= OP_IDLE;
      r_len       <= 6'd0;
      r_data      <= '0;
      r_cap       <= '0;
      r_step      <= 7'd0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_tap       <= TAP_RESET;
      r_tap_known <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_op   <= bus.cmd_op;
        r_len  <= bus.cmd_len;
        r_data <= bus.cmd_data;
        r_cap  <= '0;
        r_step <= 7'd0;
        r_tdi  <= 1'b0;
        r_tms  <= w_imm_done ? r_tms : w_tms_start;
        if (w_imm_done) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_bad;
          r_rsp_data  <= '0;
        end
      end else if (w_fall) begin
        if (w_last) begin
          r_step      <= 7'd0;
          r_tdi       <= 1'b0;
          r_tap_known <= (r_tap == TAP_RTI);
          r_tms       <= (w_state_nxt == CTL_CMD) ? w_tms_start : 1'b0;
        end else begin
          r_step <= w_step_n;
          r_tms  <= w_tms_nxt;
          r_tdi  <= w_tdi_nxt;
        end
      end else if (w_rise) begin
        r_tap <= tap_next(r_tap, r_tms);
        if (w_in_shift_cur) begin
          r_cap[w_idx_cur] <= tdo;
        end
      end
      if (w_finish) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b0;
        r_rsp_data  <= r_cap;
      end
    end
  end

`ifdef JTAG_SCAN_MASTER_TRST_EN
  logic r_trst_n;

  // trst_n is held low for the whole TAP reset segment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trst_n <= 1'b0;
    end else begin
      r_trst_n <= (w_state_nxt != CTL_TRST);
    end
  end

  assign trst_n = r_trst_n;
`endif

  assign tck           = w_tck;
  assign tms           = r_tms;
  assign tdi           = r_tdi;
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed self-checking bench for jtag_scan_master (default build, TCK_DIV=4).
module tb_jtag_scan_master;
  import jtag_scan_master_pkg::*;

  localparam int TCK_DIV = 4;
  localparam int ML      = 38;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic tck, tms, tdi;
  wire  tdo;
  int   tdo_mode = 0;

  int   checks     = 0;
  int   errors     = 0;
  int   rise_cnt   = 0;
  int   rsp_pulses = 0;
  logic tms_log [0:255];
  logic tdi_log [0:255];
  time  rise_t  [0:255];

  jtag_scan_master_if #(.MAX_LEN(ML)) bus ();

  jtag_scan_master #(.TCK_DIV(TCK_DIV), .MAX_LEN(ML)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .tck     (tck),
    .tms     (tms),
    .tdi     (tdi),
    .tdo     (tdo)
  );

  always #5 clk = ~clk;

  // 0: tdo low, 1: loopback, 2: inverted loopback
  assign tdo = (tdo_mode == 1) ? tdi : ((tdo_mode == 2) ? ~tdi : 1'b0);

  always @(posedge tck) begin
    if (rise_cnt < 256) begin
      tms_log[rise_cnt] = tms;
      tdi_log[rise_cnt] = tdi;
      rise_t[rise_cnt]  = $time;
    end
    rise_cnt = rise_cnt + 1;
  end

  always @(posedge clk) begin
    if (bus.rsp_valid === 1'b1) rsp_pulses = rsp_pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] tms_vec(input int base, input int n);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) if (base + i < 256) v[i] = tms_log[base + i];
    return v;
  endfunction

  function automatic logic [63:0] tdi_vec(input int base, input int n);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) if (base + i < 256) v[i] = tdi_log[base + i];
    return v;
  endfunction

  task automatic send(input op_e op, input logic [5:0] len, input logic [ML-1:0] data);
    @(negedge clk);
    chk("ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input op_e op, input logic [5:0] len,
                         input logic [ML-1:0] data, input logic exp_err,
                         input logic [ML-1:0] exp_data, input int exp_rises,
                         output int base, output int ncyc);
    base = rise_cnt;
    send(op, len, data);
    ncyc = 0;
    while ((bus.rsp_valid !== 1'b1) && (ncyc < 2000)) begin
      @(posedge clk);
      #1;
      ncyc = ncyc + 1;
    end
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_ready_at_rsp"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
    chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(exp_data));
    chk({tag, "_rises"}, 64'(rise_cnt - base), 64'(exp_rises));
    @(posedge clk);
    #1;
    chk({tag, "_rsp_pulse_one_cycle"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    int base, ncyc, pulses0, rise0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_IDLE;
    bus.cmd_len   = 6'd0;
    bus.cmd_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // DR len 4 after reset: auto TAP reset prefix then 1,0,0,0,0,0,1,1,0
    tdo_mode = 1;
    run_cmd("dr4", OP_DR, 6'd4, 38'hA, 1'b0, 38'hA, 15, base, ncyc);
    chk("dr4_tms", tms_vec(base, 15), 64'h305F);
    chk("dr4_tdi", tdi_vec(base, 15), 64'h1400);

    // IR len 2, inverted loopback returns 2'b01
    tdo_mode = 2;
    run_cmd("ir2", OP_IR, 6'd2, 38'h2, 1'b0, 38'h1, 8, base, ncyc);
    chk("ir2_tms", tms_vec(base, 8), 64'h63);
    chk("ir2_tdi", tdi_vec(base, 8), 64'h20);

    // DR full length, all ones looped back
    tdo_mode = 1;
    run_cmd("dr38", OP_DR, 6'd38, 38'h3F_FFFF_FFFF, 1'b0, 38'h3F_FFFF_FFFF, 43, base, ncyc);
    chk("dr38_tms", tms_vec(base, 43), 64'h0000_0300_0000_0001);
    chk("dr38_tdi", tdi_vec(base, 43), 64'h0000_01FF_FFFF_FFF8);

    // Illegal lengths answer immediately with an error
    run_cmd("dr_len0", OP_DR, 6'd0, 38'h3F_FFFF_FFFF, 1'b1, 38'h0, 0, base, ncyc);
    chk("dr_len0_latency", 64'(ncyc), 64'd0);
    run_cmd("dr_len39", OP_DR, 6'd39, 38'h3F_FFFF_FFFF, 1'b1, 38'h0, 0, base, ncyc);
    chk("dr_len39_latency", 64'(ncyc), 64'd0);

    // Idle 3 TCKs at 2*TCK_DIV clk spacing with tms low
    run_cmd("idle3", OP_IDLE, 6'd3, 38'h0, 1'b0, 38'h0, 3, base, ncyc);
    chk("idle3_tms", tms_vec(base, 3), 64'h0);
    chk("idle3_gap01", 64'(rise_t[base + 1] - rise_t[base]), 64'd80);
    chk("idle3_gap12", 64'(rise_t[base + 2] - rise_t[base + 1]), 64'd80);

    run_cmd("idle0", OP_IDLE, 6'd0, 38'h0, 1'b0, 38'h0, 0, base, ncyc);
    chk("idle0_latency", 64'(ncyc), 64'd0);

    run_cmd("tapreset", OP_RESET, 6'd0, 38'h0, 1'b0, 38'h0, 6, base, ncyc);
    chk("tapreset_tms", tms_vec(base, 6), 64'h1F);

    // Abort a 38-bit scan with reset
    tdo_mode = 1;
    send(OP_DR, 6'd38, 38'h3F_FFFF_FFFF);
    repeat (150) @(posedge clk);
    @(negedge clk);
    pulses0 = rsp_pulses;
    reset_n = 1'b0;
    #1;
    chk("abort_tck", 64'(tck), 64'd0);
    chk("abort_tms", 64'(tms), 64'd1);
    chk("abort_tdi", 64'(tdi), 64'd0);
    chk("abort_ready", 64'(bus.cmd_ready), 64'd1);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_rsp_data", 64'(bus.rsp_data), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rise0 = rise_cnt;
    repeat (400) @(posedge clk);
    #1;
    chk("abort_no_tck", 64'(rise_cnt - rise0), 64'd0);
    chk("abort_no_rsp", 64'(rsp_pulses - pulses0), 64'd0);

    run_cmd("dr4_post", OP_DR, 6'd4, 38'hA, 1'b0, 38'hA, 15, base, ncyc);
    chk("dr4_post_tms", tms_vec(base, 15), 64'h305F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
